// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and ALU operation encodings.
package cpu_types_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [3:0] {
      ALU_SLL  = 4'd0,
      ALU_SRL  = 4'd1,
      ALU_ADD  = 4'd2,
      ALU_SUB  = 4'd3,
      ALU_AND  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_XOR  = 4'd6,
      ALU_NOR  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } aluop_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Two-requester req/ack bus in front of the shared ALU arbiter.
interface alu_arbiter_if;
   import cpu_types_pkg::*;

   logic [1:0] req;
   aluop_t     op0;
   aluop_t     op1;
   word_t      a0;
   word_t      a1;
   word_t      b0;
   word_t      b1;
   logic [1:0] ack;
   word_t      result0;
   word_t      result1;
   logic       zero0;
   logic       zero1;
   logic       negative0;
   logic       negative1;
   logic       overflow0;
   logic       overflow1;
   logic       busy;

   // Arbiter side.
   modport slave (
      input  req, op0, op1, a0, a1, b0, b1,
      output ack, result0, result1, zero0, zero1,
             negative0, negative1, overflow0, overflow1, busy
   );

   // Requester side.
   modport master (
      output req, op0, op1, a0, a1, b0, b1,
      input  ack, result0, result1, zero0, zero1,
             negative0, negative1, overflow0, overflow1, busy
   );
endinterface

// File: rtl/alu_if.sv
// Connection bundle between a datapath and the combinational ALU.
interface alu_if;
   import cpu_types_pkg::*;

   aluop_t aluOp;
   word_t  portA;
   word_t  portB;
   word_t  outputPort;
   logic   negative;
   logic   overflow;
   logic   zero;

   modport alu (
      input  aluOp, portA, portB,
      output outputPort, negative, overflow, zero
   );

   modport tb (
      output aluOp, portA, portB,
      input  outputPort, negative, overflow, zero
   );
endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU with zero/negative/signed-overflow flags.
module alu
   import cpu_types_pkg::*;
(
   alu_if.alu aluif
);

   word_t res_s;
   logic  ovf_s;

   // Operation decode and signed overflow for add/subtract.
   always_comb begin
      res_s = 32'd0;
      ovf_s = 1'b0;
      case (aluif.aluOp)
         ALU_SLL:  res_s = aluif.portA << aluif.portB[4:0];
         ALU_SRL:  res_s = aluif.portA >> aluif.portB[4:0];
         ALU_ADD: begin
            res_s = aluif.portA + aluif.portB;
            ovf_s = (aluif.portA[31] == aluif.portB[31]) && (res_s[31] != aluif.portA[31]);
         end
         ALU_SUB: begin
            res_s = aluif.portA - aluif.portB;
            ovf_s = (aluif.portA[31] != aluif.portB[31]) && (res_s[31] != aluif.portA[31]);
         end
         ALU_AND:  res_s = aluif.portA & aluif.portB;
         ALU_OR:   res_s = aluif.portA | aluif.portB;
         ALU_XOR:  res_s = aluif.portA ^ aluif.portB;
         ALU_NOR:  res_s = ~(aluif.portA | aluif.portB);
         ALU_SLT:  res_s = {31'd0, ($signed(aluif.portA) < $signed(aluif.portB))};
         ALU_SLTU: res_s = {31'd0, (aluif.portA < aluif.portB)};
         default: begin
            res_s = 32'd0;
            ovf_s = 1'b0;
         end
      endcase
   end

   assign aluif.outputPort = res_s;
   assign aluif.zero       = (res_s == 32'd0);
   assign aluif.negative   = res_s[31];
   assign aluif.overflow   = ovf_s;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two req/ack requesters.
// Grant in IDLE, evaluate from operand registers in EXEC, ack in DONE.
module alu_arbiter
   import cpu_types_pkg::*;
#(
   parameter bit PRIORITY_INIT = 1'b0
)(
   input logic          CLK,
   input logic          nRST,
   alu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t     state_r;
   state_t     next_state_s;
   logic       prio_r;
   logic       grant_r;
   logic       pick_s;
   aluop_t     op_r;
   word_t      a_r;
   word_t      b_r;
   word_t      result0_r;
   word_t      result1_r;
   logic [2:0] flags0_r;   // {zero, negative, overflow}
   logic [2:0] flags1_r;
   logic [1:0] ack_s;
   logic       busy_s;

   alu_if aluif ();

   alu u_alu (
      .aluif (aluif)
   );

   // The ALU only ever sees the captured operands, never the live inputs.
   assign aluif.aluOp = op_r;
   assign aluif.portA = a_r;
   assign aluif.portB = b_r;

   // Requester selection: a lone request wins, otherwise the priority holder.
   always_comb begin
      if (bus.req == 2'b11) begin
         pick_s = prio_r;
      end else if (bus.req[1]) begin
         pick_s = 1'b1;
      end else begin
         pick_s = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.req != 2'b00) begin
               next_state_s = ST_EXEC;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_EXEC: next_state_s = ST_DONE;
         ST_DONE: next_state_s = ST_IDLE;
         default: next_state_s = ST_IDLE;
      endcase
   end

   // FSM outputs decoded from registered state only.
   always_comb begin
      ack_s  = 2'b00;
      busy_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            ack_s  = 2'b00;
            busy_s = 1'b0;
         end
         ST_EXEC: begin
            ack_s  = 2'b00;
            busy_s = 1'b1;
         end
         ST_DONE: begin
            if (grant_r) begin
               ack_s = 2'b10;
            end else begin
               ack_s = 2'b01;
            end
            busy_s = 1'b1;
         end
         default: begin
            ack_s  = 2'b00;
            busy_s = 1'b0;
         end
      endcase
   end

   // Operand capture on grant, result latch after EXEC, priority hand-off in DONE.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         prio_r    <= PRIORITY_INIT;
         grant_r   <= 1'b0;
         op_r      <= ALU_SLL;
         a_r       <= 32'd0;
         b_r       <= 32'd0;
         result0_r <= 32'd0;
         result1_r <= 32'd0;
         flags0_r  <= 3'd0;
         flags1_r  <= 3'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.req != 2'b00) begin
                  grant_r <= pick_s;
                  if (pick_s) begin
                     op_r <= bus.op1;
                     a_r  <= bus.a1;
                     b_r  <= bus.b1;
                  end else begin
                     op_r <= bus.op0;
                     a_r  <= bus.a0;
                     b_r  <= bus.b0;
                  end
               end
            end
            ST_EXEC: begin
               if (grant_r) begin
                  result1_r <= aluif.outputPort;
                  flags1_r  <= {aluif.zero, aluif.negative, aluif.overflow};
               end else begin
                  result0_r <= aluif.outputPort;
                  flags0_r  <= {aluif.zero, aluif.negative, aluif.overflow};
               end
            end
            ST_DONE: begin
               prio_r <= ~grant_r;
            end
            default: begin
               prio_r <= prio_r;
            end
         endcase
      end
   end

   assign bus.ack       = ack_s;
   assign bus.busy      = busy_s;
   assign bus.result0   = result0_r;
   assign bus.result1   = result1_r;
   assign bus.zero0     = flags0_r[2];
   assign bus.negative0 = flags0_r[1];
   assign bus.overflow0 = flags0_r[0];
   assign bus.zero1     = flags1_r[2];
   assign bus.negative1 = flags1_r[1];
   assign bus.overflow1 = flags1_r[0];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table plus hand sequences for
// reset, contention, fairness and reset during EXEC.
module tb_alu_arbiter;
   import cpu_types_pkg::*;

   logic clk;
   logic nrst;
   int   tests_run;
   int   tests_failed;

   alu_arbiter_if bus ();

   alu_arbiter #(.PRIORITY_INIT(1'b0)) dut (
      .CLK  (clk),
      .nRST (nrst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic   idx;
      aluop_t op;
      word_t  a;
      word_t  b;
      word_t  res;
      logic   z;
      logic   n;
      logic   v;
   } vec_t;

   localparam int NV = 13;
   vec_t  vecs [NV];
   word_t exp_res [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] flags_of(input logic idx);
      if (idx) return {29'd0, bus.zero1, bus.negative1, bus.overflow1};
      else     return {29'd0, bus.zero0, bus.negative0, bus.overflow0};
   endfunction

   task automatic start_req(input logic idx, input aluop_t op, input word_t a, input word_t b);
      if (idx) begin
         bus.op1 = op; bus.a1 = a; bus.b1 = b; bus.req[1] = 1'b1;
      end else begin
         bus.op0 = op; bus.a0 = a; bus.b0 = b; bus.req[0] = 1'b1;
      end
   endtask

   // Bounded wait for an ack; optionally corrupt operand inputs in cycle 1.
   task automatic wait_ack(input logic scramble, output int cyc, output logic [1:0] got);
      cyc = 0;
      got = 2'b00;
      while (got == 2'b00 && cyc < 12) begin
         @(negedge clk);
         cyc++;
         got = bus.ack;
         if (scramble && cyc == 1) begin
            bus.op0 = ALU_NOR; bus.a0 = 32'hDEADBEEF; bus.b0 = 32'h12345678;
            bus.op1 = ALU_NOR; bus.a1 = 32'hCAFEF00D; bus.b1 = 32'h87654321;
         end
      end
   endtask

   initial begin
      int         cyc;
      int         total;
      logic [1:0] got;

      tests_run    = 0;
      tests_failed = 0;

      vecs[0]  = '{1'b0, ALU_ADD,  32'h00000005, 32'h00000003, 32'h00000008, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, ALU_SUB,  32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, ALU_AND,  32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b1};
      vecs[4]  = '{1'b0, ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, ALU_OR,   32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, ALU_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, ALU_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b0, ALU_SLL,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{1'b1, ALU_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b0, ALU_SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0};

      // Reset held for two cycles with both requests up.
      nrst    = 1'b0;
      bus.req = 2'b11;
      bus.op0 = ALU_ADD; bus.a0 = 32'd1; bus.b0 = 32'd1;
      bus.op1 = ALU_ADD; bus.a1 = 32'd2; bus.b1 = 32'd2;
      @(negedge clk);
      @(negedge clk);
      check("rst_ack",     {30'd0, bus.ack}, 32'd0);
      check("rst_busy",    {31'd0, bus.busy}, 32'd0);
      check("rst_result0", bus.result0, 32'd0);
      check("rst_result1", bus.result1, 32'd0);
      check("rst_flags0",  flags_of(1'b0), 32'd0);
      check("rst_flags1",  flags_of(1'b1), 32'd0);
      nrst = 1'b1;

      // Contention: requester 0 holds priority after reset.
      bus.req = 2'b11;
      bus.op0 = ALU_SUB; bus.a0 = 32'h00000007; bus.b0 = 32'h00000007;
      bus.op1 = ALU_AND; bus.a1 = 32'hF0F0F0F0; bus.b1 = 32'h0F0F0F0F;
      wait_ack(1'b0, cyc, got);
      check("cont_lat0",    32'(cyc), 32'd2);
      check("cont_ack0",    {30'd0, got}, 32'd1);
      check("cont_result0", bus.result0, 32'd0);
      check("cont_zero0",   {31'd0, bus.zero0}, 32'd1);
      bus.req[0] = 1'b0;
      wait_ack(1'b0, cyc, got);
      check("cont_lat1",    32'(cyc), 32'd3);
      check("cont_ack1",    {30'd0, got}, 32'd2);
      check("cont_result1", bus.result1, 32'd0);
      check("cont_zero1",   {31'd0, bus.zero1}, 32'd1);
      bus.req = 2'b00;
      @(negedge clk);

      // Fairness: both requesting continuously for four transactions.
      bus.req = 2'b11;
      bus.op0 = ALU_ADD; bus.a0 = 32'd1; bus.b0 = 32'd1;
      bus.op1 = ALU_ADD; bus.a1 = 32'd2; bus.b1 = 32'd2;
      total = 0;
      for (int k = 0; k < 4; k++) begin
         wait_ack(1'b0, cyc, got);
         total += cyc;
         check("fair_cycle", 32'(total), 32'(2 + 3 * k));
         check("fair_ack",   {30'd0, got}, ((k % 2) == 0) ? 32'd1 : 32'd2);
      end
      bus.req = 2'b00;
      check("fair_result0", bus.result0, 32'd2);
      check("fair_result1", bus.result1, 32'd4);
      @(negedge clk);

      // Vector table: one transaction each, inputs corrupted during EXEC.
      exp_res[0] = bus.result0 === 32'd2 ? 32'd2 : 32'd2;
      exp_res[1] = 32'd4;
      for (int i = 0; i < NV; i++) begin
         start_req(vecs[i].idx, vecs[i].op, vecs[i].a, vecs[i].b);
         wait_ack(1'b1, cyc, got);
         check($sformatf("vec%0d_lat", i), 32'(cyc), 32'd2);
         check($sformatf("vec%0d_ack", i), {30'd0, got}, vecs[i].idx ? 32'd2 : 32'd1);
         check($sformatf("vec%0d_result", i),
               vecs[i].idx ? bus.result1 : bus.result0, vecs[i].res);
         check($sformatf("vec%0d_flags", i), flags_of(vecs[i].idx),
               {29'd0, vecs[i].z, vecs[i].n, vecs[i].v});
         check($sformatf("vec%0d_other", i),
               vecs[i].idx ? bus.result0 : bus.result1, exp_res[~vecs[i].idx]);
         exp_res[vecs[i].idx] = vecs[i].res;
         bus.req = 2'b00;
         @(negedge clk);
         check($sformatf("vec%0d_idle", i), {31'd0, bus.busy}, 32'd0);
      end

      // Reset asserted while in EXEC drops the transaction.
      start_req(1'b1, ALU_ADD, 32'd10, 32'd20);
      @(negedge clk);
      check("midrst_busy_exec", {31'd0, bus.busy}, 32'd1);
      nrst    = 1'b0;
      bus.req = 2'b00;
      @(negedge clk);
      nrst = 1'b1;
      check("midrst_ack",     {30'd0, bus.ack}, 32'd0);
      check("midrst_busy",    {31'd0, bus.busy}, 32'd0);
      check("midrst_result0", bus.result0, 32'd0);
      check("midrst_result1", bus.result1, 32'd0);
      check("midrst_flags0",  flags_of(1'b0), 32'd0);
      check("midrst_flags1",  flags_of(1'b1), 32'd0);
      @(negedge clk);
      check("midrst_noack", {30'd0, bus.ack}, 32'd0);
      start_req(1'b0, ALU_OR, 32'h00000001, 32'h00000002);
      wait_ack(1'b0, cyc, got);
      check("post_lat",     32'(cyc), 32'd2);
      check("post_ack",     {30'd0, got}, 32'd1);
      check("post_result0", bus.result0, 32'h00000003);
      check("post_result1", bus.result1, 32'd0);
      bus.req = 2'b00;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
